// File: rtl/man_tx_pkg.sv
// Shared types, constants and helpers for the multi-lane Manchester transmitter.
package man_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2
    } tx_state_e;

    localparam int   GUARD_HALVES = 4;
    localparam logic PREAMBLE     = 1'b1;

    // Even parity; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic man_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/man_tx_multi_if.sv
// Handshake and lane bus between the priority controller and the transmitter.
interface man_tx_multi_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 12
);
    logic                     tx_start;
    logic [N_CH*DATA_W-1:0]   data_in;
    logic [N_CH-1:0]          ch_en;
    logic                     busy;
    logic                     done;
    logic [N_CH-1:0]          txd;

    modport master (output tx_start, data_in, ch_en, input busy, done, txd);
    modport slave  (input tx_start, data_in, ch_en, output busy, done, txd);
endinterface

// File: rtl/man_tx_lane.sv
// One Manchester output lane: frame shift register plus registered line driver.
module man_tx_lane #(
    parameter int   F          = 14,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk_20M,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         half_phase,
    input  logic         send_active,
    input  logic         enable,
    input  logic [F-1:0] frame_in,
    output logic         txd
);
    logic [F-1:0] sr;
    logic         en_q;
    logic         cur_bit;
    logic         level;

    // half_phase/send_active describe the cycle after this edge, so txd lands registered.
    always_comb begin
        cur_bit = shift ? sr[F-2] : sr[F-1];
        level   = half_phase ? ~cur_bit : cur_bit;
    end

    always_ff @(posedge clk_20M) begin
        if (load)
            sr <= frame_in;
        else if (shift)
            sr <= {sr[F-2:0], 1'b0};
    end

    always_ff @(posedge clk_20M) begin
        if (reset) begin
            txd  <= IDLE_LEVEL;
            en_q <= 1'b0;
        end else if (load) begin
            en_q <= enable;
            txd  <= enable ? frame_in[F-1] : IDLE_LEVEL;
        end else begin
            txd  <= (send_active && en_q) ? level : IDLE_LEVEL;
        end
    end

endmodule

// File: rtl/man_tx_multi.sv
// Multi-lane Manchester frame transmitter: shared FSM and counters drive N_CH lanes in lock-step.
import man_tx_pkg::*;

module man_tx_multi #(
    parameter int   N_CH         = 3,
    parameter int   DATA_W       = 12,
    parameter int   HALF_BIT_DIV = 10,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic          clk_20M,
    input  logic          reset,
    man_tx_multi_if.slave bus
);
    localparam int F         = DATA_W + 2;
    localparam int GUARD_LEN = GUARD_HALVES * HALF_BIT_DIV;
    localparam int CNT_MAX   = (F > GUARD_LEN) ? F : GUARD_LEN;
    localparam int HALF_W    = $clog2(HALF_BIT_DIV);
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF_BIT_DIV - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(F - 1);
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_LEN - 1);

    tx_state_e         state, state_nxt;
    logic [HALF_W-1:0] half_cnt, half_cnt_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              phase, phase_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              load, shift;
    logic [N_CH-1:0]   txd_q;

    always_ff @(posedge clk_20M) begin
        if (reset) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            cnt      <= '0;
            phase    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_cnt_nxt;
            cnt      <= cnt_nxt;
            phase    <= phase_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // cnt counts frame bits in SEND and guard cycles in GUARD.
    always_comb begin
        state_nxt    = state;
        half_cnt_nxt = half_cnt;
        cnt_nxt      = cnt;
        phase_nxt    = phase;
        load         = 1'b0;
        shift        = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    load         = 1'b1;
                    state_nxt    = ST_SEND;
                    half_cnt_nxt = '0;
                    cnt_nxt      = '0;
                    phase_nxt    = 1'b0;
                end
            end
            ST_SEND: begin
                if (half_cnt == HALF_LAST) begin
                    half_cnt_nxt = '0;
                    phase_nxt    = ~phase;
                    if (phase) begin
                        shift = 1'b1;
                        if (cnt == BIT_LAST) begin
                            state_nxt = ST_GUARD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end else begin
                    half_cnt_nxt = half_cnt + HALF_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        logic [DATA_W-1:0] word;
        logic [F-1:0]      frame;

        assign word  = bus.data_in[k*DATA_W +: DATA_W];
        assign frame = {PREAMBLE, word, man_parity(64'(word))};

        man_tx_lane #(
            .F          (F),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_lane (
            .clk_20M     (clk_20M),
            .reset       (reset),
            .load        (load),
            .shift       (shift),
            .half_phase  (phase_nxt),
            .send_active (state_nxt == ST_SEND),
            .enable      (bus.ch_en[k]),
            .frame_in    (frame),
            .txd         (txd_q[k])
        );
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.txd  = txd_q;

endmodule

// File: tb/tb_man_tx_multi.sv
// Directed bench for man_tx_multi: default 3-lane instance plus a minimal 1-lane, idle-high instance.
module tb_man_tx_multi;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #25 clk = ~clk;

    man_tx_multi_if #(.N_CH(3), .DATA_W(12)) bus ();
    man_tx_multi_if #(.N_CH(1), .DATA_W(1))  bus2 ();

    man_tx_multi #(.N_CH(3), .DATA_W(12), .HALF_BIT_DIV(10), .IDLE_LEVEL(1'b0)) dut (
        .clk_20M (clk),
        .reset   (reset),
        .bus     (bus)
    );

    man_tx_multi #(.N_CH(1), .DATA_W(1), .HALF_BIT_DIV(2), .IDLE_LEVEL(1'b1)) dut2 (
        .clk_20M (clk),
        .reset   (reset),
        .bus     (bus2)
    );

    // Expected level of a 12-bit lane (H=10, idle low) in cycle T+j after acceptance at edge T.
    function automatic logic exp_line(input logic [11:0] w, input logic en, input int j);
        logic [13:0] fr;
        int          slot;
        logic        b;
        fr = {1'b1, w, ^w};
        if (!en || j < 1 || j > 280) return 1'b0;
        slot = (j - 1) / 20;
        b    = fr[13 - slot];
        return (((j - 1) % 20) >= 10) ? ~b : b;
    endfunction

    // Leaves the bench at #1 into cycle T+1, with the request accepted at edge T.
    task automatic start_frame();
        @(negedge clk);
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.txd !== 3'b000) begin errors++; $display("FAIL reset_txd: got %b expected 000", bus.txd); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus2.txd !== 1'b1) begin errors++; $display("FAIL reset_idle_high: got %b expected 1", bus2.txd); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [11:0] w0, w1, w2;
        logic [2:0]  exp;
        w0 = 12'hA5C; w1 = 12'h001; w2 = 12'h3C7;
        bus.data_in = {w2, w1, w0};
        bus.ch_en   = 3'b111;
        start_frame();
        for (int j = 1; j <= 321; j++) begin
            exp = {exp_line(w2, 1'b1, j), exp_line(w1, 1'b1, j), exp_line(w0, 1'b1, j)};
            checks++;
            if (bus.txd !== exp) begin errors++; $display("FAIL basic_txd T+%0d: got %b expected %b", j, bus.txd, exp); end
            checks++;
            if (bus.busy !== (j <= 320) || bus.done !== (j == 321)) begin
                errors++; $display("FAIL basic_handshake T+%0d: got busy=%b done=%b", j, bus.busy, bus.done);
            end
            if (j == 1 || j == 10) begin
                checks++;
                if (bus.txd[0] !== 1'b1) begin errors++; $display("FAIL preamble_high T+%0d: got %b expected 1", j, bus.txd[0]); end
            end
            if (j == 11 || j == 20) begin
                checks++;
                if (bus.txd[0] !== 1'b0) begin errors++; $display("FAIL preamble_low T+%0d: got %b expected 0", j, bus.txd[0]); end
            end
            if (j == 261 || j == 271) begin
                checks++;
                if (bus.txd[0] !== (j == 271)) begin errors++; $display("FAIL parity0_slot T+%0d: got %b", j, bus.txd[0]); end
                checks++;
                if (bus.txd[1] !== (j == 261)) begin errors++; $display("FAIL parity1_slot T+%0d: got %b", j, bus.txd[1]); end
            end
            if (j < 321) step();
        end
    endtask

    task automatic test_disabled_lane();
        logic [11:0] w0, w1, w2;
        logic [2:0]  exp;
        int          lane1_active;
        w0 = 12'h5A3; w1 = 12'hFFF; w2 = 12'h0F0;
        bus.data_in  = {w2, w1, w0};
        bus.ch_en    = 3'b101;
        lane1_active = 0;
        start_frame();
        for (int j = 1; j <= 321; j++) begin
            exp = {exp_line(w2, 1'b1, j), 1'b0, exp_line(w0, 1'b1, j)};
            if (bus.txd[1] !== 1'b0) lane1_active++;
            checks++;
            if (bus.txd !== exp) begin errors++; $display("FAIL disabled_txd T+%0d: got %b expected %b", j, bus.txd, exp); end
            if (j < 321) step();
        end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL disabled_done: got %b expected 1", bus.done); end
        checks++;
        if (lane1_active !== 0) begin errors++; $display("FAIL disabled_lane_quiet: got %0d active cycles expected 0", lane1_active); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w0, w1, w2, wn, a0, a1, a2;
        logic [2:0]  exp;
        int          jj;
        w0 = 12'h123; w1 = 12'h456; w2 = 12'h789; wn = 12'hFFF;
        bus.data_in = {w2, w1, w0};
        bus.ch_en   = 3'b111;
        @(negedge clk);
        bus.tx_start = 1'b1;
        step();
        for (int j = 1; j <= 642; j++) begin
            if (j == 5)   bus.data_in  = {wn, wn, wn};
            if (j == 49)  bus.tx_start = 1'b0;
            if (j == 50)  bus.tx_start = 1'b1;
            jj = (j <= 321) ? j : j - 321;
            if (j <= 321) begin a0 = w0; a1 = w1; a2 = w2; end
            else          begin a0 = wn; a1 = wn; a2 = wn; end
            exp = {exp_line(a2, 1'b1, jj), exp_line(a1, 1'b1, jj), exp_line(a0, 1'b1, jj)};
            checks++;
            if (bus.txd !== exp) begin errors++; $display("FAIL b2b_txd T+%0d: got %b expected %b", j, bus.txd, exp); end
            checks++;
            if (bus.busy !== (jj <= 320) || bus.done !== (jj == 321)) begin
                errors++; $display("FAIL b2b_handshake T+%0d: got busy=%b done=%b", j, bus.busy, bus.done);
            end
            if (j == 322) begin
                checks++;
                if (bus.txd !== 3'b111 || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL restart_T322: got txd=%b busy=%b expected 111 1", bus.txd, bus.busy);
                end
                bus.tx_start = 1'b0;
            end
            if (j < 642) step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] w0, w1, w2;
        logic [2:0]  exp;
        int          done_seen;
        w0 = 12'h800; w1 = 12'h7FF; w2 = 12'hC3A;
        bus.data_in = {w2, w1, w0};
        bus.ch_en   = 3'b111;
        start_frame();
        for (int j = 1; j <= 100; j++) begin
            exp = {exp_line(w2, 1'b1, j), exp_line(w1, 1'b1, j), exp_line(w0, 1'b1, j)};
            checks++;
            if (bus.txd !== exp) begin errors++; $display("FAIL prereset_txd T+%0d: got %b expected %b", j, bus.txd, exp); end
            if (j == 100) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        checks++;
        if (bus.txd !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_T101: got txd=%b busy=%b done=%b expected 000 0 0", bus.txd, bus.busy, bus.done);
        end
        done_seen = 0;
        for (int j = 0; j < 330; j++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
            step();
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
        w0 = 12'h00F; w1 = 12'hABC; w2 = 12'h555;
        bus.data_in = {w2, w1, w0};
        start_frame();
        for (int j = 1; j <= 321; j++) begin
            exp = {exp_line(w2, 1'b1, j), exp_line(w1, 1'b1, j), exp_line(w0, 1'b1, j)};
            checks++;
            if (bus.txd !== exp) begin errors++; $display("FAIL postreset_txd T+%0d: got %b expected %b", j, bus.txd, exp); end
            checks++;
            if (bus.busy !== (j <= 320) || bus.done !== (j == 321)) begin
                errors++; $display("FAIL postreset_handshake T+%0d: got busy=%b done=%b", j, bus.busy, bus.done);
            end
            if (j < 321) step();
        end
    endtask

    task automatic test_param_sweep();
        logic [2:0] fr;
        logic       b, exp;
        for (int d = 0; d < 2; d++) begin
            fr = {1'b1, d[0], d[0]};
            bus2.data_in = d[0];
            bus2.ch_en   = 1'b1;
            @(negedge clk);
            bus2.tx_start = 1'b1;
            step();
            bus2.tx_start = 1'b0;
            for (int j = 1; j <= 21; j++) begin
                if (j <= 12) begin
                    b   = fr[2 - (j - 1) / 4];
                    exp = (((j - 1) % 4) >= 2) ? ~b : b;
                end else begin
                    exp = 1'b1;
                end
                checks++;
                if (bus2.txd !== exp) begin errors++; $display("FAIL sweep_txd d=%0d T+%0d: got %b expected %b", d, j, bus2.txd, exp); end
                checks++;
                if (bus2.busy !== (j <= 20) || bus2.done !== (j == 21)) begin
                    errors++; $display("FAIL sweep_handshake d=%0d T+%0d: got busy=%b done=%b", d, j, bus2.busy, bus2.done);
                end
                if (j < 21) step();
            end
        end
    endtask

    initial begin
        bus.tx_start  = 1'b0;
        bus.data_in   = '0;
        bus.ch_en     = '0;
        bus2.tx_start = 1'b0;
        bus2.data_in  = '0;
        bus2.ch_en    = '0;
        test_reset();
        test_basic();
        step();
        test_disabled_lane();
        step();
        test_back_to_back();
        step();
        test_reset_mid_frame();
        step();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/man_tx_multi.md
# man_tx_multi

Parametrised multi-channel Manchester frame transmitter feeding the fibre/optical links to the power modules. It is the next generation of the single-lane module-control transmitter. It latches one control word per channel on a start request and serialises all channels in lock-step: preamble, data MSB-first, even parity. A guard gap follows each frame, and the block reports busy/done to the controlling priority logic. New relative to the previous generation: N channels, per-channel enable, parity, configurable bit rate and idle level, and a handshake.

## Interface
- N_CH, 3, number of output lanes (≥1)
- DATA_W, 12, control-word bits per lane (≥1)
- HALF_BIT_DIV, 10, clk_20M cycles per Manchester half-bit (≥2; 10 → 1 Mbit/s)
- IDLE_LEVEL, 1'b0, line level outside the SEND state and on disabled lanes
- clk_20M  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tx_start  in  1  request to send one frame; sampled each cycle
- data_in  in  N_CH*DATA_W  lane k word at [k*DATA_W +: DATA_W]
- ch_en  in  N_CH  per-lane enable, latched with data
- busy  out  1  frame or guard in progress
- done  out  1  one-cycle pulse at end of guard
- txd  out  N_CH  Manchester line per lane

## Operation
- Encoding: bit 1 = high half then low half; bit 0 = low half then high half. Each half is HALF_BIT_DIV cycles.
- Frame per lane: preamble bit 1, then DATA_W data bits MSB-first, then the even-parity bit (XOR of the DATA_W data bits). Total is F = DATA_W+2 bits.
- FSM states: IDLE, SEND, GUARD.
  - IDLE: if tx_start=1, latch data_in and ch_en into per-lane shift registers, set busy, go to SEND. Otherwise txd=IDLE_LEVEL.
  - SEND: a shared half-bit counter (0..HALF_BIT_DIV-1) and bit counter (0..F-1) drive all lanes together. The half-phase flag toggles on each counter wrap. The shift register advances after the second half. After the last half of bit F-1, go to GUARD.
  - GUARD: txd=IDLE_LEVEL for 4*HALF_BIT_DIV cycles, then go to IDLE. On the IDLE-entry cycle, done=1 and busy=0.
- Disabled lane (latched ch_en[k]=0): txd[k]=IDLE_LEVEL for the whole frame. Timing is otherwise unchanged.
- tx_start while busy=1: ignored, not queued. data_in and ch_en changes while busy: no effect.
- tx_start on the done cycle: accepted, which gives back-to-back frames.
- Reset mid-frame: at the next edge, abort and return to IDLE. All outputs take their reset values; no done pulse.
- Widths: half counter $clog2(HALF_BIT_DIV); bit/guard counter $clog2(max(F, 4*HALF_BIT_DIV)+1). Counters never wrap beyond their terminal values.

## Timing
- Reset values: txd = {N_CH{IDLE_LEVEL}}, busy=0, done=0, FSM=IDLE, counters 0.
- Let tx_start be accepted at edge T, with H=HALF_BIT_DIV and L=2*F*H.
  - busy=1 and the first preamble half are visible from cycle T+1.
  - SEND occupies cycles T+1..T+L.
  - GUARD occupies cycles T+L+1..T+L+4H.
  - done=1 and busy=0 at cycle T+L+4H+1.
- txd is registered; no combinational path from inputs to txd, busy or done.
- All lanes transition on the same cycles; skew between lanes is 0 cycles.

## Structure
- Shared package man_tx_pkg:
  - FSM state enum (IDLE/SEND/GUARD)
  - GUARD_HALVES=4
  - PREAMBLE=1'b1
  - function man_parity(data) returning the even-parity bit
- Sub-module man_tx_lane, instantiated N_CH times:
  - inputs: shift register, load/shift strobes, half-phase flag, send-active flag, enable
  - output: one registered txd bit
- Top-level man_tx_multi holds the FSM, shared counters and handshake.

## Test plan
- Basic frame, N_CH=3, DATA_W=12, H=10. Stimulus: lane0=12'hA5C (parity 0), ch_en=3'b111, tx_start at T. Required:
  - txd[0] high on T+1..T+10, low on T+11..T+20 (preamble)
  - data bits follow in 20-cycle bit slots, ending with a parity-0 slot (low then high) on T+261..T+280
  - done pulse at T+321
- Parity 1: lane1=12'h001. Required: final bit slot is high then low, i.e. txd[1]=1 on T+261..T+270.
- Disabled lane: ch_en=3'b101. Required: txd[1] stays at IDLE_LEVEL for the whole frame; lanes 0 and 2 toggle as normal; done still at T+321.
- Handshake: tx_start held high continuously. Required:
  - a second frame starts exactly at T+322
  - tx_start pulses at T+50 are ignored
  - data_in changed at T+5 does not alter the first frame
- Reset mid-frame: reset=1 at T+100. Required: at T+101, txd=IDLE_LEVEL, busy=0, no done pulse; the next tx_start produces a full, correct frame.
- Parameter sweep: DATA_W=1, H=2, IDLE_LEVEL=1, N_CH=1. Required: F=3 and L=12; done at T+21; idle line high.
